mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/arb_id_fifo.sv | 65 ++++++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared constants for the instruction/data memory port arbiter:
//   master identifiers, outstanding-transaction limit and size encodings.
// Revision: 1.0
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  // Master identifiers, stored in the in-order id FIFO
  typedef logic master_id_t;
  localparam master_id_t ID_INST = 1'b0;
  localparam master_id_t ID_DATA = 1'b1;

  // Maximum number of accepted-but-not-returned transactions
  localparam int OUTSTANDING_MAX = 2;

  // Transfer size encodings on the shared port
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/arb_id_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arb_id_fifo
//   Two-entry in-order FIFO holding the master id of every accepted request
//   so that responses can be routed back in request order.
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     i_push, i_id      enqueue an id (ignored when full)
//     i_pop             dequeue the head (ignored when empty)
//     o_head            id at the head
//     o_full, o_empty   occupancy flags
// Revision: 1.0
// ---------------------------------------------------------------------------
module arb_id_fifo
  import mem_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  master_id_t i_id,
  input  logic       i_pop,
  output master_id_t o_head,
  output logic       o_full,
  output logic       o_empty
);

  logic [1:0] r_mem;
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == 2'(OUTSTANDING_MAX));
  assign o_empty = (r_count == 2'd0);
  assign o_head  = r_mem[r_rptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem   <= '0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_id;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : arb_id_fifo
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one split-transaction memory port between an instruction-fetch
//   master and a load/store master. Data normally wins; an instruction
//   request that has waited through STARVE_LIMIT data grants wins next.
//   The owner is frozen while a request is stalled on mem_addr_ok. Up to two
//   transactions may be outstanding; responses are routed by an id FIFO.
//   Ports:
//     clk, reset                    clock, synchronous active-high reset
//     inst_*                        fetch master request/response
//     data_*                        load/store master request/response
//     mem_*                         shared memory port
//     err                           sticky: response with nothing outstanding
// Revision: 1.0
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] C_STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic                r_lock;
  master_id_t          r_owner;
  logic [STARVE_W-1:0] r_starve;
  logic                r_err;

  master_id_t w_owner;
  logic       w_owner_req;
  logic       w_accept;
  logic       w_ret;
  logic       w_pop;
  master_id_t w_head;
  logic       w_full;
  logic       w_empty;

  // Owner selection: frozen while a request is stalled, otherwise data
  // priority with an anti-starvation override for instruction fetch.
  always_comb begin
    w_owner = r_owner;
    if (!r_lock) begin
      if (inst_req && (r_starve == C_STARVE_MAX)) w_owner = ID_INST;
      else if (data_req)                          w_owner = ID_DATA;
      else if (inst_req)                          w_owner = ID_INST;
      else                                        w_owner = r_owner;
    end
  end

  assign w_owner_req = (w_owner == ID_DATA) ? data_req : inst_req;
  assign mem_req     = w_owner_req && !w_full && !reset;
  assign w_accept    = mem_req && mem_addr_ok;

  // Fetches are always word reads
  assign mem_wr    = (w_owner == ID_DATA) ? data_wr    : 1'b0;
  assign mem_size  = (w_owner == ID_DATA) ? data_size  : SIZE_WORD;
  assign mem_wstrb = (w_owner == ID_DATA) ? data_wstrb : 4'h0;
  assign mem_addr  = (w_owner == ID_DATA) ? data_addr  : inst_addr;
  assign mem_wdata = (w_owner == ID_DATA) ? data_wdata : 32'h0;

  assign inst_addr_ok = w_accept && (w_owner == ID_INST);
  assign data_addr_ok = w_accept && (w_owner == ID_DATA);

  // Responses during reset are dropped; with nothing outstanding they only
  // flag an error.
  assign w_ret = mem_data_ok && !reset;
  assign w_pop = w_ret && !w_empty;

  assign inst_data_ok = w_pop && (w_head == ID_INST);
  assign data_data_ok = w_pop && (w_head == ID_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign err          = r_err;

  arb_id_fifo u_id_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_accept),
    .i_id    (w_owner),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock   <= 1'b0;
      r_owner  <= ID_INST;
      r_starve <= '0;
      r_err    <= 1'b0;
    end else begin
      r_lock  <= mem_req && !mem_addr_ok;
      r_owner <= w_owner;
      if (w_ret && w_empty) r_err <= 1'b1;
      if (!inst_req || (w_accept && (w_owner == ID_INST))) begin
        r_starve <= '0;
      end else if (w_accept && (w_owner == ID_DATA) && (r_starve != C_STARVE_MAX)) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed self-checking bench for mem_port_arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .err(err)
  );

  // Advance one clock; inputs change and outputs are checked 1-2ns after posedge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
  endtask

  task automatic test_reset();
    reset = 1; inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    inst_addr = 32'h0000_1000; data_addr = 32'h0000_2000;
    data_wr = 0; data_size = 2; data_wstrb = 0; data_wdata = 0; mem_rdata = 32'hDEAD_BEEF;
    step(); #1;
    n_cmp++; if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b required 00000",
        {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
    step();
    reset = 0; idle_inputs(); #1;
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", err); end
    n_cmp++; if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
      n_fail++; $display("FAIL idle_outputs: got %b required 00000",
        {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
    step();
  endtask

  task automatic test_simultaneous();
    inst_req = 1; inst_addr = 32'h0000_0100;
    data_req = 1; data_addr = 32'h0000_0800; data_wr = 0; data_size = 2;
    mem_addr_ok = 1; #1;
    n_cmp++; if (mem_addr !== 32'h0000_0800) begin n_fail++; $display("FAIL simul_addr: got %h required 00000800", mem_addr); end
    n_cmp++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin n_fail++; $display("FAIL simul_grant: got %b required 10", {data_addr_ok, inst_addr_ok}); end
    step();
    idle_inputs(); mem_data_ok = 1; mem_rdata = 32'hA5A5_0001; #1;
    n_cmp++; if ({data_data_ok, inst_data_ok} !== 2'b10) begin n_fail++; $display("FAIL simul_return: got %b required 10", {data_data_ok, inst_data_ok}); end
    n_cmp++; if (data_rdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL simul_rdata: got %h required a5a50001", data_rdata); end
    step();
    idle_inputs();
  endtask

  task automatic test_lock();
    // Data stalled for 3 cycles; inst rises on the second
    data_req = 1; data_wr = 1; data_size = 0; data_wstrb = 4'b0010;
    data_addr = 32'h0000_3001; data_wdata = 32'h0000_AB00;
    inst_addr = 32'h0000_0200; mem_addr_ok = 0;
    for (int i = 0; i < 3; i++) begin
      inst_req = (i >= 1); #1;
      n_cmp++; if ({mem_req, mem_addr, mem_wr, mem_wstrb} !== {1'b1, 32'h0000_3001, 1'b1, 4'b0010}) begin
        n_fail++; $display("FAIL lock_data_hold%0d: got req=%b addr=%h wr=%b strb=%b required 1 00003001 1 0010",
          i, mem_req, mem_addr, mem_wr, mem_wstrb); end
      step();
    end
    mem_addr_ok = 1; #1;
    n_cmp++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin n_fail++; $display("FAIL lock_data_accept: got %b required 10", {data_addr_ok, inst_addr_ok}); end
    step();
    // Inst stalled; data rises during the stall and must not steal the port
    data_req = 0; inst_req = 1; mem_addr_ok = 0;
    step();
    data_req = 1; #1;
    n_cmp++; if ({mem_addr, mem_wr, mem_size, mem_wstrb, mem_wdata} !== {32'h0000_0200, 1'b0, 2'd2, 4'h0, 32'h0}) begin
      n_fail++; $display("FAIL lock_inst_hold: got addr=%h wr=%b size=%0d strb=%h wdata=%h required 00000200 0 2 0 0",
        mem_addr, mem_wr, mem_size, mem_wstrb, mem_wdata); end
    step();
    mem_addr_ok = 1; #1;
    n_cmp++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin n_fail++; $display("FAIL lock_inst_accept: got %b required 10", {inst_addr_ok, data_addr_ok}); end
    step();
    inst_req = 0; #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL lock_full_gate: got %b required 0", mem_req); end
    step();
    idle_inputs(); mem_data_ok = 1; mem_rdata = 32'h1111_2222; #1;
    n_cmp++; if ({data_data_ok, inst_data_ok} !== 2'b10) begin n_fail++; $display("FAIL lock_ret1: got %b required 10", {data_data_ok, inst_data_ok}); end
    step(); #1;
    n_cmp++; if ({data_data_ok, inst_data_ok} !== 2'b01) begin n_fail++; $display("FAIL lock_ret2: got %b required 01", {data_data_ok, inst_data_ok}); end
    step();
    idle_inputs(); data_wr = 0; data_size = 2; data_wstrb = 0;
  endtask

  task automatic test_two_outstanding();
    inst_req = 1; inst_addr = 32'h0000_0400; mem_addr_ok = 1; #1;
    n_cmp++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL two_inst_accept: got %b required 1", inst_addr_ok); end
    step();
    inst_req = 0; data_req = 1; data_addr = 32'h0000_0900; #1;
    n_cmp++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL two_data_accept: got %b required 1", data_addr_ok); end
    step();
    inst_req = 1; #1;
    n_cmp++; if ({mem_req, inst_addr_ok, data_addr_ok} !== 3'b000) begin n_fail++; $display("FAIL two_count2_gate: got %b required 000", {mem_req, inst_addr_ok, data_addr_ok}); end
    step();
    idle_inputs(); mem_data_ok = 1; mem_rdata = 32'h1234_5678; #1;
    n_cmp++; if ({inst_data_ok, data_data_ok, inst_rdata} !== {2'b10, 32'h1234_5678}) begin
      n_fail++; $display("FAIL two_ret_inst: got ok=%b rdata=%h required 10 12345678", {inst_data_ok, data_data_ok}, inst_rdata); end
    step();
    mem_rdata = 32'h8765_4321; #1;
    n_cmp++; if ({inst_data_ok, data_data_ok, data_rdata} !== {2'b01, 32'h8765_4321}) begin
      n_fail++; $display("FAIL two_ret_data: got ok=%b rdata=%h required 01 87654321", {inst_data_ok, data_data_ok}, data_rdata); end
    step();
    idle_inputs();
  endtask

  task automatic test_starvation();
    logic [7:0] exp_d;
    exp_d = 8'b1110_1110;  // bit 7 first: D D D I D D D I
    inst_req = 1; data_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < 8; i++) begin
      mem_data_ok = (i > 0); mem_rdata = 32'(i); #1;
      n_cmp++; if ({data_addr_ok, inst_addr_ok} !== {exp_d[7-i], ~exp_d[7-i]}) begin
        n_fail++; $display("FAIL starve_grant%0d: got data/inst=%b required %b", i,
          {data_addr_ok, inst_addr_ok}, {exp_d[7-i], ~exp_d[7-i]}); end
      step();
    end
    idle_inputs(); mem_data_ok = 1; #1;
    n_cmp++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin n_fail++; $display("FAIL starve_drain: got %b required 10", {inst_data_ok, data_data_ok}); end
    step();
    idle_inputs(); #1;
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL starve_err: got %b required 0", err); end
  endtask

  task automatic test_spurious();
    idle_inputs(); mem_data_ok = 1; #1;
    n_cmp++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin n_fail++; $display("FAIL spur_no_pulse: got %b required 00", {inst_data_ok, data_data_ok}); end
    step();
    mem_data_ok = 0; #1;
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL spur_err_set: got %b required 1", err); end
    step(); step(); #1;
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL spur_err_sticky: got %b required 1", err); end
    reset = 1;
    step();
    reset = 0; #1;
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL spur_err_reset: got %b required 0", err); end
    step();
  endtask

  task automatic test_reset_mid();
    inst_req = 1; inst_addr = 32'h0000_0500; mem_addr_ok = 1;
    step();
    inst_req = 0; data_req = 1; data_addr = 32'h0000_0A00;
    step();
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL mid_count2: got %b required 0", mem_req); end
    reset = 1; mem_data_ok = 1;  // response during reset must be dropped
    step();
    reset = 0; idle_inputs(); #1;
    n_cmp++; if ({mem_req, err} !== 2'b00) begin n_fail++; $display("FAIL mid_after_reset: got req/err=%b required 00", {mem_req, err}); end
    mem_data_ok = 1; #1;
    n_cmp++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin n_fail++; $display("FAIL mid_stale_ret: got %b required 00", {inst_data_ok, data_data_ok}); end
    step();
    mem_data_ok = 0; #1;
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL mid_err: got %b required 1", err); end
    step();
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_lock();
    test_two_outstanding();
    test_starvation();
    test_spurious();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
